// File: rtl/icache_2way_param.sv
// Parametrised 2-way set-associative read-only instruction cache.
// Contains its own line-refill engine, a whole-cache flush sequencer and saturating hit/miss counters.
module icache_2way_param #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned SETS      = 128,
  parameter int unsigned BLK_WORDS = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic              flush,
  output logic [DATA_W-1:0] data_out,
  output logic              hit,
  output logic              fsm_busy,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_stall,
  input  logic              mem_data_vld,
  input  logic [DATA_W-1:0] mem_data,
  output logic              wrt_mem,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned B   = $clog2(DATA_W / 8);
  localparam int unsigned OW  = $clog2(BLK_WORDS);
  localparam int unsigned IW  = $clog2(SETS);
  localparam int unsigned LoW = B + OW;
  localparam int unsigned TW  = ADDR_W - LoW - IW;
  localparam logic [OW:0]   ReqEnd  = (OW + 1)'(BLK_WORDS);
  localparam logic [OW-1:0] RcvLast = OW'(BLK_WORDS - 1);
  localparam logic [IW-1:0] SetLast = IW'(SETS - 1);

  typedef enum logic [1:0] {StIdle, StFill, StFlush} state_e;

  logic [DATA_W-1:0] data_q [2][SETS][BLK_WORDS];
  logic [TW-1:0]     tag_q  [2][SETS];
  logic [SETS-1:0]   valid_q [2];
  logic [SETS-1:0]   lru_q;

  state_e            state_q, state_d;
  logic [OW:0]       req_q, req_d;
  logic [OW-1:0]     rcv_q, rcv_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              vic_q, vic_d;
  logic              flush_pend_q, flush_pend_d;
  logic [IW-1:0]     fl_q, fl_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [OW-1:0] off;
  logic [IW-1:0] idx, fset;
  logic [TW-1:0] tag, ftag;
  logic [1:0]    way_hit;
  logic          hit_way, victim, miss, fill_wr, last_word;

  always_comb begin
    off     = OW'(addr >> B);
    idx     = IW'(addr >> LoW);
    tag     = TW'(addr >> (LoW + IW));
    fset    = IW'(base_q >> LoW);
    ftag    = TW'(base_q >> (LoW + IW));
    way_hit = '0;
    for (int w = 0; w < 2; w++) begin
      way_hit[w] = valid_q[w][idx] && (tag_q[w][idx] == tag);
    end
    hit_way   = ~way_hit[0];
    hit       = rd_en && (state_q == StIdle) && (|way_hit);
    data_out  = hit ? data_q[hit_way][idx][off] : '0;
    miss      = rd_en && (state_q == StIdle) && !(|way_hit) && !flush;
    // Fill an empty way first; only evict by LRU when both are in use.
    victim    = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);
    fill_wr   = (state_q == StFill) && mem_data_vld;
    last_word = fill_wr && (rcv_q == RcvLast);
    mem_rd    = (state_q == StFill) && (req_q < ReqEnd);
    mem_addr  = mem_rd ? base_q + (ADDR_W'(req_q) << B) : '0;
    fsm_busy  = (state_q != StIdle);
    wrt_mem   = 1'b0;
    hit_cnt   = hit_cnt_q;
    miss_cnt  = miss_cnt_q;
  end

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    rcv_d        = rcv_q;
    base_d       = base_q;
    vic_d        = vic_q;
    flush_pend_d = flush_pend_q;
    fl_d         = fl_q;
    hit_cnt_d    = (hit && hit_cnt_q != '1) ? hit_cnt_q + 1'b1 : hit_cnt_q;
    miss_cnt_d   = (miss && miss_cnt_q != '1) ? miss_cnt_q + 1'b1 : miss_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (flush) begin
          state_d = StFlush;
          fl_d    = '0;
        end else if (miss) begin
          state_d      = StFill;
          base_d       = (addr >> LoW) << LoW;
          vic_d        = victim;
          req_d        = '0;
          rcv_d        = '0;
          flush_pend_d = 1'b0;
        end
      end
      StFill: begin
        if (mem_rd && !mem_stall) req_d = req_q + 1'b1;
        if (flush) flush_pend_d = 1'b1;
        if (fill_wr) rcv_d = rcv_q + 1'b1;
        if (last_word) begin
          state_d      = (flush_pend_q || flush) ? StFlush : StIdle;
          fl_d         = '0;
          flush_pend_d = 1'b0;
        end
      end
      StFlush: begin
        fl_d = fl_q + 1'b1;
        if (fl_q == SetLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      req_q        <= '0;
      rcv_q        <= '0;
      base_q       <= '0;
      vic_q        <= 1'b0;
      flush_pend_q <= 1'b0;
      fl_q         <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      valid_q[0]   <= '0;
      valid_q[1]   <= '0;
      lru_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      rcv_q        <= rcv_d;
      base_q       <= base_d;
      vic_q        <= vic_d;
      flush_pend_q <= flush_pend_d;
      fl_q         <= fl_d;
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      if (hit) lru_q[idx] <= ~hit_way;
      // The victim's old line is dropped up front so a partial fill can never hit.
      if (miss) valid_q[victim][idx] <= 1'b0;
      if (last_word) begin
        valid_q[vic_q][fset] <= 1'b1;
        lru_q[fset]          <= ~vic_q;
      end
      if (state_q == StFlush) begin
        valid_q[0][fl_q] <= 1'b0;
        valid_q[1][fl_q] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_wr) begin
      data_q[vic_q][fset][rcv_q] <= mem_data;
      if (last_word) tag_q[vic_q][fset] <= ftag;
    end
  end

endmodule
